// File: rtl/dbus_timer.sv
// Memory-mapped timer/compare responder on the CPU data bus (CTRL/COUNT/COMPARE/STATUS).
// Latency: reads are combinational (zero cycles); writes take effect on the next rising edge.
// Backpressure: none, the bus has no stall path and every access completes in its own cycle.
module dbus_timer #(
  parameter logic [31:0] BASE     = 32'hFFFF0000,
  parameter int          PRESCALE = 4,
  parameter int          PSW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic        sel,
  output logic        irq
);

  logic           ctrl_en;
  logic           ctrl_ar;
  logic           ctrl_ie;
  logic [31:0]    count;
  logic [31:0]    compare;
  logic           match;
  logic [PSW-1:0] presc;

  logic       wr;
  logic [1:0] offs;
  logic       wr_ctrl;
  logic       wr_count;
  logic       wr_compare;
  logic       wr_status;
  logic       tick;
  logic       hit;

  assign sel        = (memaddr[31:4] == BASE[31:4]);
  assign offs       = memaddr[3:2];
  assign wr         = memwrite & sel;
  assign wr_ctrl    = wr & (offs == 2'd0);
  assign wr_count   = wr & (offs == 2'd1);
  assign wr_compare = wr & (offs == 2'd2);
  assign wr_status  = wr & (offs == 2'd3);

  assign tick = ctrl_en & (presc == PSW'(PRESCALE - 1));
  // Compare against the pre-edge COUNT/COMPARE so same-cycle CPU writes never mask a match.
  assign hit  = tick & (count == compare);
  assign irq  = ctrl_ie & match;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (wr_ctrl) begin
      presc <= '0;
    end else if (ctrl_en) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en <= 1'b0;
      ctrl_ar <= 1'b0;
      ctrl_ie <= 1'b0;
      compare <= 32'hFFFFFFFF;
    end else begin
      if (wr_ctrl) begin
        ctrl_en <= memwritedata[0];
        ctrl_ar <= memwritedata[1];
        ctrl_ie <= memwritedata[2];
      end
      if (wr_compare) begin
        compare <= memwritedata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (wr_count) begin
      count <= memwritedata;
    end else if (hit && ctrl_ar) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 32'd1;
    end
  end

  // A match in the same cycle as a W1C keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      match <= 1'b0;
    end else if (hit) begin
      match <= 1'b1;
    end else if (wr_status && memwritedata[0]) begin
      match <= 1'b0;
    end
  end

  always_comb begin
    memreaddata = 32'h0;
    if (sel) begin
      case (offs)
        2'd0:    memreaddata = {29'h0, ctrl_ie, ctrl_ar, ctrl_en};
        2'd1:    memreaddata = count;
        2'd2:    memreaddata = compare;
        default: memreaddata = {31'h0, match};
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_timer.sv
// Scoreboarded bench for dbus_timer: stimulus queues expectations, a negedge monitor checks them.
module tb_dbus_timer;

  localparam logic [31:0] B = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        sel;
  logic        irq;

  typedef struct packed {
    logic        cd;
    logic [31:0] d;
    logic        ci;
    logic        i;
    logic        cs;
    logic        s;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  logic  chk_vld = 1'b0;
  logic  fin     = 1'b0;
  logic  fin_ack = 1'b0;
  int    n_run   = 0;
  int    n_fail  = 0;

  dbus_timer #(.BASE(B), .PRESCALE(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .memreaddata  (memreaddata),
    .sel          (sel),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  function automatic exp_t ed(input logic [31:0] d);
    exp_t e;
    e = '0;
    e.cd = 1'b1;
    e.d = d;
    return e;
  endfunction

  function automatic exp_t edi(input logic [31:0] d, input logic i);
    exp_t e;
    e = ed(d);
    e.ci = 1'b1;
    e.i = i;
    return e;
  endfunction

  function automatic exp_t eds(input logic [31:0] d, input logic s);
    exp_t e;
    e = ed(d);
    e.cs = 1'b1;
    e.s = s;
    return e;
  endfunction

  task automatic look(input logic [31:0] a, input exp_t e, input string nm);
    @(posedge clk); #1;
    reset = 1'b0; memwrite = 1'b0; memaddr = a; memwritedata = 32'h0;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    chk_vld = 1'b1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    reset = 1'b0; memwrite = 1'b1; memaddr = a; memwritedata = d;
    chk_vld = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    reset = 1'b0; memwrite = 1'b0; memaddr = 32'h0; memwritedata = 32'h0;
    chk_vld = 1'b0;
  endtask

  task automatic rst_cycle(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    reset = 1'b1; memwrite = 1'b1; memaddr = a; memwritedata = d;
    chk_vld = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL scoreboard_underflow: DUT output checked with no expectation queued");
      end else begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        if (e.cd) begin
          n_run++;
          if (memreaddata !== e.d) begin
            n_fail++;
            $display("FAIL %s memreaddata: got %h want %h (addr %h)", nm, memreaddata, e.d, memaddr);
          end
        end
        if (e.ci) begin
          n_run++;
          if (irq !== e.i) begin
            n_fail++;
            $display("FAIL %s irq: got %b want %b", nm, irq, e.i);
          end
        end
        if (e.cs) begin
          n_run++;
          if (sel !== e.s) begin
            n_fail++;
            $display("FAIL %s sel: got %b want %b", nm, sel, e.s);
          end
        end
      end
    end
    if (fin && !fin_ack) begin
      n_run++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL scoreboard_leftover: got %0d pending want 0", exp_q.size());
      end
      fin_ack = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; memwrite = 1'b0; memaddr = 32'h0; memwritedata = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values, decode, alignment, and out-of-range writes
    look(B + 32'h0, edi(32'h0, 1'b0), "t1_ctrl");
    look(B + 32'h4, ed(32'h0), "t1_count");
    look(B + 32'h8, eds(32'hFFFFFFFF, 1'b1), "t1_compare");
    look(B + 32'hC, edi(32'h0, 1'b0), "t1_status");
    look(B + 32'h10, eds(32'h0, 1'b0), "t1_unsel");
    look(B + 32'h9, ed(32'hFFFFFFFF), "t1_misalign");
    wr(B + 32'h14, 32'd1234);
    wr(32'h0000_0004, 32'd99);
    look(B + 32'h4, ed(32'h0), "t1_nosel_write");

    // Auto-reload with interrupt enabled
    wr(B + 32'h8, 32'd3);
    wr(B + 32'h0, 32'd7);
    for (int i = 0; i < 16; i++) look(B + 32'h4, edi(32'(i / 4), 1'b0), "t2_count");
    look(B + 32'h4, edi(32'h0, 1'b1), "t2_reload");
    look(B + 32'hC, edi(32'h1, 1'b1), "t2_match");

    // Free-running past the match, interrupt disabled, W1C behaviour
    wr(B + 32'h0, 32'd0);
    wr(B + 32'hC, 32'd1);
    wr(B + 32'h4, 32'd0);
    wr(B + 32'h8, 32'd2);
    wr(B + 32'h0, 32'd1);
    for (int i = 0; i < 16; i++) look(B + 32'h4, edi(32'(i / 4), 1'b0), "t3_count");
    look(B + 32'hC, edi(32'h1, 1'b0), "t3_match_noirq");
    wr(B + 32'hC, 32'd0);
    look(B + 32'hC, ed(32'h1), "t3_w0_noeffect");
    wr(B + 32'hC, 32'd1);
    look(B + 32'hC, ed(32'h0), "t3_w1c");
    look(B + 32'h4, ed(32'd5), "t3_count_cont");

    // 32-bit wrap does not produce a match
    wr(B + 32'h0, 32'd0);
    wr(B + 32'h4, 32'hFFFFFFFF);
    wr(B + 32'h8, 32'd5);
    wr(B + 32'h0, 32'd1);
    look(B + 32'h4, ed(32'hFFFFFFFF), "t4_hold0");
    idle(); idle();
    look(B + 32'h4, ed(32'hFFFFFFFF), "t4_hold3");
    look(B + 32'h4, ed(32'h0), "t4_wrap");
    look(B + 32'hC, ed(32'h0), "t4_nomatch");

    // Same-cycle collisions with a tick
    idle();
    wr(B + 32'h4, 32'd100);
    look(B + 32'h4, ed(32'd100), "t5_wr_wins");
    idle(); idle();
    look(B + 32'h4, ed(32'd100), "t5_hold");
    look(B + 32'h4, ed(32'd101), "t5_incr");
    wr(B + 32'h8, 32'd102);
    idle(); idle();
    look(B + 32'h4, ed(32'd102), "t5_at_cmp");
    idle(); idle();
    wr(B + 32'hC, 32'd1);
    look(B + 32'hC, ed(32'h1), "t5_set_wins");
    look(B + 32'h4, ed(32'd103), "t5_after_match");
    wr(B + 32'hC, 32'd1);
    idle();
    wr(B + 32'h8, 32'd104);
    look(B + 32'hC, ed(32'h0), "t5_cleared");
    look(B + 32'h4, ed(32'd104), "t5_at_cmp2");
    wr(B + 32'h4, 32'd7);
    look(B + 32'h4, ed(32'd7), "t5_wr_on_match");
    look(B + 32'hC, edi(32'h1, 1'b0), "t5_old_count_match");

    // Reset mid-operation overrides a simultaneous write
    wr(B + 32'h0, 32'd5);
    look(B + 32'hC, edi(32'h1, 1'b1), "t6_irq_before");
    rst_cycle(B + 32'h4, 32'd55);
    look(B + 32'h4, edi(32'h0, 1'b0), "t6_count");
    look(B + 32'h0, ed(32'h0), "t6_ctrl");
    look(B + 32'h8, ed(32'hFFFFFFFF), "t6_compare");
    look(B + 32'hC, edi(32'h0, 1'b0), "t6_status");
    repeat (4) idle();
    look(B + 32'h4, ed(32'h0), "t6_stopped");
    idle();

    fin = 1'b1;
    for (int k = 0; k < 10 && !fin_ack; k++) @(posedge clk);
    if (!fin_ack) begin
      $display("FAIL finish_handshake: monitor did not acknowledge");
      $fatal(1, "handshake");
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
